// File: rtl/pxs_stream_gen.sv
// rtl/pxs_stream_gen.sv - 640x480 VGA timing source for the RGBStr pixel stream
// Optional build macro: PXS_TESTPATTERN_EN (white border plus colour bars in the active area)
`timescale 1ns/1ps
module pxs_stream_gen #(
  parameter int unsigned h_visible = 640,
  parameter int unsigned h_front   = 16,
  parameter int unsigned h_sync    = 96,
  parameter int unsigned h_back    = 48,
  parameter int unsigned v_visible = 480,
  parameter int unsigned v_front   = 10,
  parameter int unsigned v_sync    = 2,
  parameter int unsigned v_back    = 33,
  parameter logic [2:0]  bg_color  = 3'b000
) (
  input  logic        px_clk,
  input  logic        reset,
  input  logic        en,
  output logic [25:0] RGBStr_o,
  output logic        frame_o
);

  // Timing boundaries, all held in the 10-bit counter domain
  localparam logic [9:0] H_VIS    = 10'(h_visible);
  localparam logic [9:0] H_SYNC_S = 10'(h_visible + h_front);
  localparam logic [9:0] H_SYNC_E = 10'(h_visible + h_front + h_sync);
  localparam logic [9:0] H_LAST   = 10'(h_visible + h_front + h_sync + h_back - 1);
  localparam logic [9:0] V_VIS    = 10'(v_visible);
  localparam logic [9:0] V_SYNC_S = 10'(v_visible + v_front);
  localparam logic [9:0] V_SYNC_E = 10'(v_visible + v_front + v_sync);
  localparam logic [9:0] V_LAST   = 10'(v_visible + v_front + v_sync + v_back - 1);

  // Idle word: no colour, origin coordinates, both syncs deasserted (high), not active
  localparam logic [25:0] RESET_WORD = {3'b000, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0};

  logic [9:0] r_hc;
  logic [9:0] r_vc;

  logic       w_active;
  logic       w_hs;
  logic       w_vs;
  logic [2:0] w_rgb;
  logic       w_frame;

  // Horizontal/vertical counters; vertical steps only on the horizontal wrap
  always_ff @(posedge px_clk) begin
    if (reset) begin
      r_hc <= 10'd0;
      r_vc <= 10'd0;
    end else if (en) begin
      if (r_hc == H_LAST) begin
        r_hc <= 10'd0;
        if (r_vc == V_LAST) begin
          r_vc <= 10'd0;
        end else begin
          r_vc <= r_vc + 10'd1;
        end
      end else begin
        r_hc <= r_hc + 10'd1;
      end
    end
  end

  // Decode the current counter position into stream fields
  always_comb begin
    w_active = (r_hc < H_VIS) && (r_vc < V_VIS);
    w_hs     = !((r_hc >= H_SYNC_S) && (r_hc < H_SYNC_E));
    w_vs     = !((r_vc >= V_SYNC_S) && (r_vc < V_SYNC_E));
    w_frame  = (r_hc == 10'd0) && (r_vc == V_VIS);
    w_rgb    = 3'b000;
    if (w_active) begin
`ifdef PXS_TESTPATTERN_EN
      if ((r_hc == 10'd0) || (r_hc == H_VIS - 10'd1) ||
          (r_vc == 10'd0) || (r_vc == V_VIS - 10'd1)) begin
        w_rgb = 3'b111;
      end else begin
        w_rgb = r_hc[8:6];
      end
`else
      w_rgb = bg_color;
`endif
    end
  end

  // Output register; holding it while en is low stalls the whole stream
  always_ff @(posedge px_clk) begin
    if (reset) begin
      RGBStr_o <= RESET_WORD;
      frame_o  <= 1'b0;
    end else if (en) begin
      RGBStr_o <= {w_rgb, r_hc, r_vc, w_hs, w_vs, w_active};
      frame_o  <= w_frame;
    end
  end

endmodule

// File: tb/tb_pxs_stream_gen.sv
// tb/tb_pxs_stream_gen.sv - scoreboard bench for pxs_stream_gen (full-size and reduced-timing instances)
`timescale 1ns/1ps
module tb_pxs_stream_gen;

  // Instance A: default VGA timing, non-zero background colour
  localparam int AHV = 640, AHF = 16, AHS = 96, AHB = 48;
  localparam int AVV = 480, AVF = 10, AVS = 2,  AVB = 33;
  localparam logic [2:0] ABG = 3'b010;
  // Instance B: reduced timing so whole frames fit in a short run
  localparam int BHV = 40, BHF = 4, BHS = 6, BHB = 6;
  localparam int BVV = 20, BVF = 2, BVS = 2, BVB = 3;
  localparam logic [2:0] BBG = 3'b000;
  localparam int BHT = BHV + BHF + BHS + BHB;  // 56
  localparam int BVT = BVV + BVF + BVS + BVB;  // 27

  logic        clk = 1'b0;
  logic        rst_a, en_a, rst_b, en_b;
  logic [25:0] wa, wb;
  logic        fa, fb;

  always #20 clk = ~clk;

  pxs_stream_gen #(
    .h_visible(AHV), .h_front(AHF), .h_sync(AHS), .h_back(AHB),
    .v_visible(AVV), .v_front(AVF), .v_sync(AVS), .v_back(AVB), .bg_color(ABG)
  ) dut_a (
    .px_clk(clk), .reset(rst_a), .en(en_a), .RGBStr_o(wa), .frame_o(fa)
  );

  pxs_stream_gen #(
    .h_visible(BHV), .h_front(BHF), .h_sync(BHS), .h_back(BHB),
    .v_visible(BVV), .v_front(BVF), .v_sync(BVS), .v_back(BVB), .bg_color(BBG)
  ) dut_b (
    .px_clk(clk), .reset(rst_b), .en(en_b), .RGBStr_o(wb), .frame_o(fb)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [26:0] qa[$];
  logic [26:0] qb[$];

  int ah, av, bh, bv;
  logic [26:0] alast, blast;

  int cyc = 0;
  int hs_low_a = 0;
  int vs_low_b = 0;
  int frame_cnt_b = 0;
  int frame_cyc_b = 0;
  int frame_cyc_prev_b = 0;
  logic [19:0] frame_xy_b = '0;

  function automatic logic [26:0] exp_word(int hv, int hf, int hs, int vv, int vf, int vs,
                                           logic [2:0] bg, int h, int v);
    logic act, hsn, vsn, frm;
    logic [2:0] rgb;
    act = (h < hv) && (v < vv);
    hsn = !((h >= hv + hf) && (h < hv + hf + hs));
    vsn = !((v >= vv + vf) && (v < vv + vf + vs));
    frm = (h == 0) && (v == vv);
    rgb = 3'b000;
    if (act) begin
`ifdef PXS_TESTPATTERN_EN
      if (h == 0 || h == hv - 1 || v == 0 || v == vv - 1) rgb = 3'b111;
      else rgb = 3'((h / 64) % 8);
`else
      rgb = bg;
`endif
    end
    return {frm, rgb, 10'(h), 10'(v), hsn, vsn, act};
  endfunction

  function automatic logic [9:0] xc(input logic [25:0] w);
    return w[22:13];
  endfunction

  function automatic logic [9:0] yc(input logic [25:0] w);
    return w[12:3];
  endfunction

  task automatic check(input string tag, input logic [26:0] obs, input logic [26:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: push expectations for the inputs now applied, then compare after the edge
  task automatic cycle();
    logic [26:0] e;
    if (rst_a) begin
      e = {1'b0, 26'h6}; ah = 0; av = 0;
    end else if (en_a) begin
      e = exp_word(AHV, AHF, AHS, AVV, AVF, AVS, ABG, ah, av);
      ah++;
      if (ah == AHV + AHF + AHS + AHB) begin
        ah = 0; av++;
        if (av == AVV + AVF + AVS + AVB) av = 0;
      end
    end else begin
      e = alast;
    end
    alast = e; qa.push_back(e);

    if (rst_b) begin
      e = {1'b0, 26'h6}; bh = 0; bv = 0;
    end else if (en_b) begin
      e = exp_word(BHV, BHF, BHS, BVV, BVF, BVS, BBG, bh, bv);
      bh++;
      if (bh == BHT) begin
        bh = 0; bv++;
        if (bv == BVT) bv = 0;
      end
    end else begin
      e = blast;
    end
    blast = e; qb.push_back(e);

    @(posedge clk);
    #1;
    cyc++;
    check("stream_a", {fa, wa}, qa.pop_front());
    check("stream_b", {fb, wb}, qb.pop_front());
    if (!wa[2]) hs_low_a++;
    if (!wb[1]) vs_low_b++;
    if (fb) begin
      frame_cnt_b++;
      frame_cyc_prev_b = frame_cyc_b;
      frame_cyc_b = cyc;
      frame_xy_b = {xc(wb), yc(wb)};
    end
  endtask

  task automatic run_a_to(input int x, input int y, input int budget);
    int k = 0;
    while (!(xc(wa) == 10'(x) && yc(wa) == 10'(y)) && k < budget) begin
      cycle(); k++;
    end
    check("reach_a", {7'd0, xc(wa), yc(wa)}, {7'd0, 10'(x), 10'(y)});
  endtask

  task automatic run_b_to(input int x, input int y, input int budget);
    int k = 0;
    while (!(xc(wb) == 10'(x) && yc(wb) == 10'(y)) && k < budget) begin
      cycle(); k++;
    end
    check("reach_b", {7'd0, xc(wb), yc(wb)}, {7'd0, 10'(x), 10'(y)});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp_rgb;
    rst_a = 1'b1; en_a = 1'b1; rst_b = 1'b1; en_b = 1'b1;
    @(negedge clk);

    // ---------------- Instance A: default timing ----------------
    repeat (3) cycle();
    check("reset_word_a", {fa, wa}, {1'b0, 26'h6});
    rst_a = 1'b0;
    hs_low_a = 0;
    cycle();
    check("first_word", {1'b0, wa}, {1'b0, 3'(ABG), 10'd0, 10'd0, 1'b1, 1'b1, 1'b1} |
                                    27'(0));
    repeat (639) cycle();
    check("word640_xc", 27'(xc(wa)), 27'd639);
    check("word640_act", 27'(wa[0]), 27'd1);
    cycle();
    check("word641_xc", 27'(xc(wa)), 27'd640);
    check("word641_act_rgb", {23'd0, wa[25:23], wa[0]}, 27'd0);
    run_a_to(799, 0, 200);
    check("hs_low_count", 27'(hs_low_a), 27'd96);
    cycle();
    check("line_wrap", {7'd0, xc(wa), yc(wa)}, {7'd0, 10'd0, 10'd1});

`ifdef PXS_TESTPATTERN_EN
    exp_rgb = 3'b111;
`else
    exp_rgb = ABG;
`endif
    run_a_to(0, 5, 4000);
    check("rgb_0_5", 27'(wa[25:23]), 27'(exp_rgb));
`ifdef PXS_TESTPATTERN_EN
    exp_rgb = 3'b001;
`endif
    run_a_to(70, 5, 100);
    check("rgb_70_5", 27'(wa[25:23]), 27'(exp_rgb));
`ifdef PXS_TESTPATTERN_EN
    exp_rgb = 3'b111;
`endif
    run_a_to(639, 5, 700);
    check("rgb_639_5", 27'(wa[25:23]), 27'(exp_rgb));
    run_a_to(700, 5, 100);
    check("rgb_700_5", 27'(wa[25:23]), 27'd0);

    // Stall: the word at XC=100 repeats for the five stalled cycles
    run_a_to(100, 10, 4000);
    en_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall_hold", {7'd0, xc(wa), yc(wa)}, {7'd0, 10'd100, 10'd10});
    end
    en_a = 1'b1;
    cycle();
    check("stall_resume", {7'd0, xc(wa), yc(wa)}, {7'd0, 10'd101, 10'd10});
    rst_a = 1'b1;

    // ---------------- Instance B: reduced timing, full frames ----------------
    repeat (2) cycle();
    check("reset_word_b", {fb, wb}, {1'b0, 26'h6});
    rst_b = 1'b0;
    vs_low_b = 0; frame_cnt_b = 0;
    run_b_to(BHT - 1, BVT - 1, 2000);
    check("vs_low_count", 27'(vs_low_b), 27'(BVS * BHT));
    check("frame_once", 27'(frame_cnt_b), 27'd1);
    check("frame_pos", 27'(frame_xy_b), {7'd0, 10'd0, 10'(BVV)});
    cycle();
    check("frame_wrap", {7'd0, xc(wb), yc(wb)}, 27'd0);
    run_b_to(0, BVV, 2000);
    check("frame_period", 27'(frame_cyc_b - frame_cyc_prev_b), 27'(BHT * BVT));

    // Reset mid-frame aborts the frame with no stray frame pulse
    run_b_to(30, 15, 2000);
    rst_b = 1'b1;
    cycle();
    check("midreset_word", {fb, wb}, {1'b0, 26'h6});
    rst_b = 1'b0;
    frame_cnt_b = 0;
    cycle();
    check("midreset_origin", {7'd0, xc(wb), yc(wb)}, 27'd0);
    run_b_to(BHT - 1, BVV - 1, 2000);
    check("midreset_no_frame", 27'(frame_cnt_b), 27'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
